// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams plus the FIFO write side shared by fifo_wr_arbiter.
// The arbiter uses the master modport; sources, FIFO and bench use slave.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_write_en;
  logic [DATA_W-1:0]         fifo_data_in;
  logic                      fifo_full;
  logic [IDX_W-1:0]          grant_id;
  logic                      busy;

  modport master (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_write_en, fifo_data_in, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_write_en, fifo_data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ streams.
// Define FIFO_WR_ARB_STATS_EN to add the stat_beats/stat_stall counters.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_wr_arbiter_if.master     bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_beats,
  output logic [15:0]           stat_stall
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CW    = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   beat_cnt;

  logic               is_own;
  logic               own_valid;
  logic               own_last;
  logic [DATA_W-1:0]  own_data;
  logic               xfer;
  logic               last_beat;
  logic               rel;
  logic [IDX_W-1:0]   ptr_next;
  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [CW-1:0]      cand;

  logic [NUM_REQ-1:0] ready_o;
  logic               we_o;
  logic [DATA_W-1:0]  data_o;
  logic [IDX_W-1:0]   gid_o;
  logic               busy_o;

  // Current owner's stream signals
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign is_own    = (state == OWN);
  assign xfer      = is_own && own_valid && !bus.fifo_full;
  assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));
  // A stall keeps ownership; only a finishing transfer or an abandon releases
  assign rel       = is_own && ((xfer && (own_last || last_beat)) || !own_valid);
  assign ptr_next  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!pick_vld && bus.req_valid[cand[IDX_W-1:0]]) begin
        pick     = cand[IDX_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (xfer) beat_cnt <= beat_cnt + CNT_W'(1);
          if (rel) begin
            state  <= IDLE;
            rr_ptr <= ptr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port outputs follow the state register directly, so reset clears them at once
  always_comb begin
    ready_o = '0;
    we_o    = 1'b0;
    data_o  = '0;
    gid_o   = '0;
    busy_o  = 1'b0;
    if (is_own) begin
      busy_o = 1'b1;
      gid_o  = owner;
      we_o   = xfer;
      data_o = own_data;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (owner == IDX_W'(i)) ready_o[i] = !bus.fifo_full;
      end
    end
  end

  assign bus.req_ready     = ready_o;
  assign bus.fifo_write_en = we_o;
  assign bus.fifo_data_in  = data_o;
  assign bus.grant_id      = gid_o;
  assign bus.busy          = busy_o;

`ifdef FIFO_WR_ARB_STATS_EN
  // Saturating per-requester beat counters and a stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (xfer && (owner == IDX_W'(i)) && (stat_beats[i*16 +: 16] != 16'hFFFF))
          stat_beats[i*16 +: 16] <= stat_beats[i*16 +: 16] + 16'd1;
      end
      if (is_own && bus.fifo_full && own_valid && (stat_stall != 16'hFFFF))
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus random traffic
// against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0] stat_beats;
  logic [15:0]     stat_stall;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_beats (stat_beats),
    .stat_stall (stat_stall)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    bit           last;
  } beat_t;

  typedef struct {
    bit           busy;
    int           gid;
    logic [N-1:0] ready;
    bit           we;
    logic [W-1:0] d;
  } exp_t;

  beat_t src_q[N][$];
  bit    mute[N];
  exp_t  exp_q[$];
  exp_t  mon_e;

  // Reference model: who owns the port, how many beats so far, where the rotation points
  bit m_own;
  int m_owner, m_ptr, m_beats, m_stall;
  int m_cnt[N];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input int i, input logic [W-1:0] d, input bit last);
    beat_t b;
    b.d = d;
    b.last = last;
    src_q[i].push_back(b);
  endtask

  task automatic model_reset();
    m_own = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_stall = 0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      mute[i] = 0;
      src_q[i].delete();
    end
    exp_q.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, advance the model
  task automatic step(input bit full);
    logic [N-1:0]   v, l;
    logic [N*W-1:0] dat;
    exp_t           e;
    int             c;
    @(posedge clk);
    #1;
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk($sformatf("stat_beats[%0d]", i), 32'(stat_beats[i*16 +: 16]), m_cnt[i]);
    chk("stat_stall", 32'(stat_stall), m_stall);
`endif
    for (int i = 0; i < N; i++) begin
      v[i] = (src_q[i].size() > 0) && !mute[i];
      l[i] = (src_q[i].size() > 0) ? src_q[i][0].last : 1'b0;
      dat[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0].d : W'($urandom);
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = dat;
    bus.fifo_full = full;

    e.busy = 0; e.gid = 0; e.ready = '0; e.we = 0; e.d = '0;
    if (m_own) begin
      e.busy = 1;
      e.gid  = m_owner;
      if (!full) e.ready[m_owner] = 1'b1;
      if (!v[m_owner]) begin
        m_own = 0;
        m_ptr = (m_owner + 1) % N;
      end else if (full) begin
        if (m_stall < 16'hFFFF) m_stall++;
      end else begin
        e.we = 1;
        e.d  = dat[m_owner*W +: W];
        m_beats++;
        if (m_cnt[m_owner] < 16'hFFFF) m_cnt[m_owner]++;
        void'(src_q[m_owner].pop_front());
        if (l[m_owner] || m_beats == MB) begin
          m_own = 0;
          m_ptr = (m_owner + 1) % N;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!m_own && v[c]) begin
          m_own = 1;
          m_owner = c;
          m_beats = 0;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("busy", 32'(bus.busy), 32'(mon_e.busy));
      chk("grant_id", 32'(bus.grant_id), mon_e.gid);
      chk("req_ready", 32'(bus.req_ready), 32'(mon_e.ready));
      chk("fifo_write_en", 32'(bus.fifo_write_en), 32'(mon_e.we));
      if (mon_e.we) chk("fifo_data_in", 32'(bus.fifo_data_in), 32'(mon_e.d));
      if (!mon_e.busy) chk("fifo_data_in_idle", 32'(bus.fifo_data_in), 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_write_en", 32'(bus.fifo_write_en), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_data", 32'(bus.fifo_data_in), 32'd0);
    reset_dut();

    // Single requester, three-beat packet
    push_beat(0, 8'hA1, 0);
    push_beat(0, 8'hA2, 0);
    push_beat(0, 8'hA3, 1);
    repeat (6) step(0);
    chk("rr_ptr_after_single", 32'(dut.rr_ptr), 32'd1);

    // All four requesting continuously, bursts capped at MAX_BURST
    reset_dut();
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 25; b++) push_beat(i, W'(i * 32 + b), 0);
    repeat (26) step(0);

    // Backpressure mid-burst on requester 2
    reset_dut();
    for (int b = 0; b < 6; b++) push_beat(2, W'(8'hC0 + b), 0);
    repeat (3) step(0);
    repeat (5) step(1);
    repeat (4) step(0);
    chk("stall_model_count", 32'(m_stall), 32'd5);

    // Abandon: requester 1 drops valid after two beats
    reset_dut();
    for (int b = 0; b < 5; b++) push_beat(1, W'(8'h10 + b), 0);
    repeat (3) step(0);
    mute[1] = 1;
    for (int b = 0; b < 3; b++) begin
      push_beat(0, W'(8'h50 + b), 0);
      push_beat(3, W'(8'h70 + b), 0);
    end
    repeat (2) step(0);
    chk("grant_after_abandon", 32'(m_owner), 32'd3);
    repeat (4) step(0);

    // Asynchronous reset in the middle of a burst
    reset_dut();
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 5; b++) push_beat(i, W'(8'h80 + i * 8 + b), 0);
    repeat (3) step(0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("async_rst_write_en", 32'(bus.fifo_write_en), 32'd0);
    reset_dut();
    for (int b = 0; b < 3; b++) begin
      push_beat(0, W'(8'h90 + b), 0);
      push_beat(2, W'(8'hB0 + b), 0);
    end
    repeat (2) step(0);
    chk("first_grant_after_rst", 32'(bus.grant_id), 32'd0);
    repeat (8) step(0);

    // Random traffic
    reset_dut();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() < 3 && $urandom_range(0, 2) == 0)
          push_beat(i, W'($urandom), $urandom_range(0, 3) == 0);
        mute[i] = ($urandom_range(0, 7) == 0);
      end
      step($urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
